// File: rtl/mux_scan_pkg.sv
// Shared mode constants, FSM encoding and index-width helper for the scanning multiplexer.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_n_to_1_if.sv
// Source-side inputs and registered channel outputs of the N-to-1 scanning multiplexer.
interface mux_scan_n_to_1_if #(
  parameter int N_CH = 4,
  parameter int W    = 4
);
  import mux_scan_pkg::*;

  localparam int SEL_W = sel_width(N_CH);

  logic [N_CH*W-1:0] din;
  logic              mode;
  logic [SEL_W-1:0]  man_sel;
  logic [N_CH-1:0]   en_mask;
  logic [W-1:0]      dout;
  logic [SEL_W-1:0]  ch_sel;
  logic [N_CH-1:0]   ch_onehot;
  logic              valid;
  logic              scan_wrap;

  modport master (
    output din, mode, man_sel, en_mask,
    input  dout, ch_sel, ch_onehot, valid, scan_wrap
  );

  modport slave (
    input  din, mode, man_sel, en_mask,
    output dout, ch_sel, ch_onehot, valid, scan_wrap
  );

endinterface

// File: rtl/rr_next_ch.sv
// Combinational round-robin search: next enabled channel strictly after cur, modulo N_CH.
module rr_next_ch #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [N_CH-1:0]  en_mask,
  output logic [SEL_W-1:0] nxt,
  output logic             found,
  output logic             wrap
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest enabled channel is the last write.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = 0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(cur) + i) % N_CH;
      if (en_mask[idx[SEL_W-1:0]]) begin
        nxt   = idx[SEL_W-1:0];
        found = 1'b1;
      end
    end
    wrap = found && (nxt < cur);
  end

endmodule

// File: rtl/mux_scan_n_to_1.sv
// N-channel W-bit mux with registered outputs, manual select or self-timed round-robin scan.
// One-cycle latency; a one-cycle HOLD state follows reset release.
module mux_scan_n_to_1
  import mux_scan_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 4,
  parameter int SCAN_DIV = 4
) (
  input logic              clk,
  input logic              rst,
  mux_scan_n_to_1_if.slave bus
);

  localparam int SEL_W = sel_width(N_CH);
  localparam int PW    = $clog2(SCAN_DIV + 1);

  state_t           state;
  logic [PW-1:0]    presc_q;
  logic [SEL_W-1:0] ch_sel_q;
  logic [W-1:0]     dout_q;
  logic [N_CH-1:0]  oh_q;
  logic             valid_q;
  logic             wrap_q;

  logic [PW-1:0]    presc_eff;
  logic             tc;
  logic             advance;
  logic             man_ok;
  logic             scan_vld;
  logic [SEL_W-1:0] rr_nxt;
  logic [SEL_W-1:0] scan_nxt;
  logic             rr_found;
  logic             rr_wrap;

  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] d, input logic [SEL_W-1:0] k);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++)
      if (k == SEL_W'(i)) r = d[i*W +: W];
    return r;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] k);
    logic [N_CH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++)
      if (k == SEL_W'(i)) r[i] = 1'b1;
    return r;
  endfunction

  rr_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr (
    .cur     (ch_sel_q),
    .en_mask (bus.en_mask),
    .nxt     (rr_nxt),
    .found   (rr_found),
    .wrap    (rr_wrap)
  );

  // Entering SCAN from another state restarts the dwell count from zero.
  assign presc_eff = (state == ST_SCAN) ? presc_q : '0;
  assign tc        = (presc_eff == PW'(SCAN_DIV - 1));
  assign advance   = tc && rr_found;
  assign scan_nxt  = advance ? rr_nxt : ch_sel_q;
  assign scan_vld  = |(onehot(scan_nxt) & bus.en_mask);
  assign man_ok    = (int'(bus.man_sel) < N_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HOLD;
      presc_q  <= '0;
      ch_sel_q <= '0;
      dout_q   <= '0;
      oh_q     <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          state <= (bus.mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        end
        default: begin
          if (bus.mode == MODE_MANUAL) begin
            state  <= ST_MANUAL;
            wrap_q <= 1'b0;
            if (man_ok) begin
              ch_sel_q <= bus.man_sel;
              dout_q   <= pick(bus.din, bus.man_sel);
              oh_q     <= onehot(bus.man_sel);
              valid_q  <= 1'b1;
            end else begin
              oh_q    <= '0;
              valid_q <= 1'b0;
            end
          end else begin
            state    <= ST_SCAN;
            presc_q  <= tc ? '0 : presc_eff + PW'(1);
            ch_sel_q <= scan_nxt;
            dout_q   <= pick(bus.din, scan_nxt);
            oh_q     <= scan_vld ? onehot(scan_nxt) : '0;
            valid_q  <= scan_vld;
            wrap_q   <= advance && rr_wrap;
          end
        end
      endcase
    end
  end

  assign bus.dout      = dout_q;
  assign bus.ch_sel    = ch_sel_q;
  assign bus.ch_onehot = oh_q;
  assign bus.valid     = valid_q;
  assign bus.scan_wrap = wrap_q;

endmodule

// File: tb/tb_mux_scan_n_to_1.sv
// Directed bench: 4-channel instance for the main scenarios, 3-channel instance for out-of-range select.
module tb_mux_scan_n_to_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_scan_n_to_1_if #(.N_CH(4), .W(4)) b4();
  mux_scan_n_to_1_if #(.N_CH(3), .W(4)) b3();

  mux_scan_n_to_1 #(.N_CH(4), .W(4), .SCAN_DIV(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  mux_scan_n_to_1 #(.N_CH(3), .W(4), .SCAN_DIV(4)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  // {dout, ch_sel, ch_onehot, valid, scan_wrap}
  logic [11:0] obs4;
  logic [10:0] obs3;
  assign obs4 = {b4.dout, b4.ch_sel, b4.ch_onehot, b4.valid, b4.scan_wrap};
  assign obs3 = {b3.dout, b3.ch_sel, b3.ch_onehot, b3.valid, b3.scan_wrap};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_scan(input logic [3:0] mask);
    rst = 1'b1;
    step();
    rst = 1'b0;
    b4.mode    = 1'b1;
    b4.en_mask = mask;
    step();
  endtask

  task automatic test_reset();
    b4.din = 16'h4321; b4.mode = 1'b0; b4.man_sel = 2'd0; b4.en_mask = 4'hF;
    b3.din = 12'h321;  b3.mode = 1'b0; b3.man_sel = 2'd0; b3.en_mask = 3'h7;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (obs4 !== 12'h000) begin errors++; $display("FAIL reset4 got %h want 000", obs4); end
    checks++;
    if (obs3 !== 11'h000) begin errors++; $display("FAIL reset3 got %h want 000", obs3); end
    rst = 1'b0;
    step();
    checks++;
    if (obs4 !== 12'h000) begin errors++; $display("FAIL hold4 got %h want 000", obs4); end
    checks++;
    if (obs3 !== 11'h000) begin errors++; $display("FAIL hold3 got %h want 000", obs3); end
  endtask

  task automatic test_manual();
    logic [11:0] exp;
    b4.mode = 1'b0;
    b4.man_sel = 2'd2;
    step();
    exp = {4'd3, 2'd2, 4'b0100, 1'b1, 1'b0};
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL manual_sel2 got %h want %h", obs4, exp); end
    b4.man_sel = 2'd0;
    step();
    exp = {4'd1, 2'd0, 4'b0001, 1'b1, 1'b0};
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL manual_sel0 got %h want %h", obs4, exp); end
    b4.man_sel = 2'd3;
    b4.en_mask = 4'h0;
    step();
    exp = {4'd4, 2'd3, 4'b1000, 1'b1, 1'b0};
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL manual_sel3 got %h want %h", obs4, exp); end
  endtask

  task automatic test_scan_all();
    logic [11:0] exp;
    int c;
    go_scan(4'hF);
    for (int k = 0; k < 20; k++) begin
      step();
      c = ((k + 1) / 4) % 4;
      exp = {4'(c + 1), 2'(c), 4'(1 << c), 1'b1, (k == 15)};
      checks++;
      if (obs4 !== exp) begin errors++; $display("FAIL scan_all k=%0d got %h want %h", k, obs4, exp); end
    end
  endtask

  task automatic test_scan_sparse();
    logic [11:0] exp;
    int c;
    logic v;
    go_scan(4'b1010);
    for (int k = 0; k < 15; k++) begin
      step();
      c = (k < 3) ? 0 : (k < 7) ? 1 : (k < 11) ? 3 : 1;
      v = (k >= 3);
      exp = {4'(c + 1), 2'(c), v ? 4'(1 << c) : 4'b0000, v, (k == 11)};
      checks++;
      if (obs4 !== exp) begin errors++; $display("FAIL scan_sparse k=%0d got %h want %h", k, obs4, exp); end
    end
    b4.en_mask = 4'b0000;
    for (int k = 15; k < 20; k++) begin
      step();
      exp = {4'd2, 2'd1, 4'b0000, 1'b0, 1'b0};
      checks++;
      if (obs4 !== exp) begin errors++; $display("FAIL scan_nomask k=%0d got %h want %h", k, obs4, exp); end
    end
  endtask

  task automatic test_nonpow2();
    logic [10:0] exp;
    b3.mode = 1'b0;
    b3.man_sel = 2'd1;
    step();
    exp = {4'd2, 2'd1, 3'b010, 1'b1, 1'b0};
    checks++;
    if (obs3 !== exp) begin errors++; $display("FAIL np2_sel1 got %h want %h", obs3, exp); end
    b3.man_sel = 2'd3;
    for (int k = 0; k < 2; k++) begin
      step();
      exp = {4'd2, 2'd1, 3'b000, 1'b0, 1'b0};
      checks++;
      if (obs3 !== exp) begin errors++; $display("FAIL np2_sel3 k=%0d got %h want %h", k, obs3, exp); end
    end
    b3.man_sel = 2'd2;
    step();
    exp = {4'd3, 2'd2, 3'b100, 1'b1, 1'b0};
    checks++;
    if (obs3 !== exp) begin errors++; $display("FAIL np2_sel2 got %h want %h", obs3, exp); end
  endtask

  task automatic test_midreset_toggle();
    logic [11:0] exp;
    go_scan(4'hF);
    for (int k = 0; k < 9; k++) step();
    exp = {4'd3, 2'd2, 4'b0100, 1'b1, 1'b0};
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL mid_pre got %h want %h", obs4, exp); end
    rst = 1'b1;
    step();
    checks++;
    if (obs4 !== 12'h000) begin errors++; $display("FAIL mid_reset got %h want 000", obs4); end
    checks++;
    if (u4.presc_q !== '0) begin errors++; $display("FAIL mid_presc got %0d want 0", u4.presc_q); end
    rst = 1'b0;
    b4.mode = 1'b1;
    step();
    for (int k = 0; k < 9; k++) step();
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL mid_rerun got %h want %h", obs4, exp); end
    b4.mode = 1'b0;
    b4.man_sel = 2'd2;
    step();
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL mid_manual got %h want %h", obs4, exp); end
    b4.mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs4 !== exp) begin errors++; $display("FAIL mid_dwell k=%0d got %h want %h", k, obs4, exp); end
    end
    step();
    exp = {4'd4, 2'd3, 4'b1000, 1'b1, 1'b0};
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL mid_advance got %h want %h", obs4, exp); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_all();
    test_scan_sparse();
    test_nonpow2();
    test_midreset_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end

endmodule
